net_resolver_bus: RTL and testbench
===================================

// Module: net_resolver_bus
// PURPOSE
//  Clocked, parametrised multi-driver bus resolver modelling Verilog net semantics
//  (wand, wor, tri, trireg) as synthesizable logic. Sits between NUM_DRV source ports
//  and one shared registered bus. Adds round-robin arbitration with burst lock in the
//  tri modes, contention counting, and trireg charge retention with timed decay.
// PARAMETERS
//  WIDTH    8   data width of each driver and of the bus
//  NUM_DRV  4   number of drivers (2..16)
//  DECAY    4   trireg hold cycles before float; 0 = hold indefinitely
//  CNT_W    8   width of the saturating contention counter
// PORTS
//  clk        in   1              rising-edge clock
//  rst        in   1              synchronous reset, active-high
//  mode       in   2              0 WAND, 1 WOR, 2 TRI, 3 TRIREG
//  drv_en     in   NUM_DRV        driver i actively drives (0 = high-Z)
//  drv_data   in   NUM_DRV*WIDTH  driver i data at [i*WIDTH +: WIDTH]
//  drv_last   in   NUM_DRV        last beat of driver i burst (releases lock)
//  clr_cnt    in   1              synchronous clear of conflict_cnt
//  bus_out    out  WIDTH          resolved bus value (registered)
//  bus_valid  out  1              bus_out derived from >=1 driver this cycle
//  bus_z      out  1              bus floating (no driver, retention expired)
//  grant      out  NUM_DRV        one-hot driver selected in TRI/TRIREG, else 0
//  conflict   out  1              >1 driver enabled in TRI/TRIREG this cycle
//  conflict_cnt out CNT_W         saturating count of conflict cycles
// BEHAVIOUR
//  - One clock; reset synchronous, active-high. All outputs registered, latency 1.
//  - Reset: bus_out=0, bus_valid=0, bus_z=1, grant=0, conflict=0, conflict_cnt=0,
//    rr pointer=0, lock=0, decay counter=0. rst mid-burst drops lock and grant.
//  - WAND: bus_out = AND of enabled drivers' data; WOR: OR of enabled drivers.
//    Disabled drivers ignored (high-Z). grant=0, conflict=0 in these modes.
//  - TRI/TRIREG: no lock -> grant first enabled driver at/after rr pointer (wrap at
//    NUM_DRV-1 -> 0); lock set. Locked -> grant held while that driver's drv_en=1.
//    Lock released after a cycle with grant & drv_last, or when granted drv_en drops;
//    rr pointer := granted index + 1 (mod NUM_DRV). Single-cycle drv_last at grant
//    = one-beat burst. bus_out = granted driver's data.
//  - No driver enabled: all modes except TRIREG -> bus_valid=0, bus_z=1, bus_out=0.
//    TRIREG -> bus_out holds last value, bus_z=0 for DECAY cycles, then bus_z=1,
//    bus_out=0. DECAY=0 holds forever. Any enabled driver reloads the decay counter.
//  - conflict = 1 when mode>=2 and popcount(drv_en)>1 (registered). conflict_cnt
//    +1 per such cycle, saturates at all-ones; clr_cnt wins over increment same cycle.
//  - mode change: takes effect next cycle; lock released, rr pointer kept,
//    TRIREG decay counter cleared.
//  - Granted driver drops drv_en while others enabled: new grant same decision cycle
//    (no idle bubble).
// STRUCTURE
//  - Package net_resolve_pkg: MODE_WAND/MODE_WOR/MODE_TRI/MODE_TRIREG 2-bit
//    localparams, popcount and one-hot-to-index functions.
//  - Sub-module rr_lock_arbiter (NUM_DRV): req, last, grant one-hot, lock, pointer.
//  - Top: wand/wor reduction, data mux, decay counter, conflict counter, out regs.
// TESTING (WIDTH=8, NUM_DRV=4, DECAY=4, CNT_W=8)
//  - WAND, en=0011, data0=F0, data1=3C -> bus_out=30 next cycle; WOR -> FC;
//    en=0000 -> bus_z=1, bus_valid=0, bus_out=00.
//  - TRI, en=1010 from reset -> grant=0010, data1 out, conflict=1, cnt=1; hold 3
//    cycles then drv_last[1]=1 -> next grant=1000, cnt=4.
//  - TRIREG, drv2 drives A5 then en=0000 -> bus_out=A5, bus_z=0 for 4 cycles,
//    then bus_z=1, bus_out=00; re-enable mid-decay -> counter reloads.
//  - conflict_cnt saturation: 300 conflict cycles -> FF held; clr_cnt with conflict
//    same cycle -> 00.
//  - rst asserted mid-burst (grant=0100) -> next cycle all outputs at reset values,
//    next arbitration starts at driver 0.
//  - mode TRI->WOR while locked -> grant=0, OR result next cycle; back to TRI ->
//    fresh arbitration from saved pointer.

Source files
------------

// File: rtl/net_resolve_pkg.sv
// Shared definitions for the multi-driver bus resolver: net-mode encodings
// and small combinational helpers sized for the largest supported driver count.
package net_resolve_pkg;

  localparam logic [1:0] MODE_WAND   = 2'd0;
  localparam logic [1:0] MODE_WOR    = 2'd1;
  localparam logic [1:0] MODE_TRI    = 2'd2;
  localparam logic [1:0] MODE_TRIREG = 2'd3;

  // Upper bound on NUM_DRV; the helpers below work on vectors of this width.
  localparam int MAX_DRV = 16;

  // Number of set bits in a zero-extended driver-enable vector.
  function automatic logic [4:0] popcount16(input logic [15:0] v);
    logic [4:0] c;
    c = '0;
    for (int i = 0; i < MAX_DRV; i++) begin
      c = c + {4'd0, v[i]};
    end
    return c;
  endfunction

  // Index of the set bit in a one-hot vector (0 when the vector is empty).
  function automatic logic [3:0] onehot_to_idx(input logic [15:0] oh);
    logic [3:0] idx;
    idx = '0;
    for (int i = 0; i < MAX_DRV; i++) begin
      if (oh[i]) begin
        idx = idx | 4'(i);
      end
    end
    return idx;
  endfunction

endpackage

// File: rtl/rr_lock_arbiter.sv
// Round-robin arbiter with burst lock. Once a driver is granted it keeps the
// bus until it drops its request or completes a cycle with its last flag set;
// the pointer then moves just past it. A new winner is chosen in the same
// decision as the release, so there is no idle bubble between bursts.
//
// Handshake: req[i] is a level request; grant is the registered one-hot
// owner; grant_nxt is the decision being registered this cycle, offered so
// the owner's data can be captured on the same edge as the grant.
//
// The lock flag (lock) and round-robin pointer (ptr) are the arbiter's state.
module rr_lock_arbiter
  import net_resolve_pkg::*;
#(
  parameter  int NUM_DRV = 4,
  localparam int IW      = $clog2(NUM_DRV)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               enable,
  input  logic               flush,
  input  logic [NUM_DRV-1:0] req,
  input  logic [NUM_DRV-1:0] last,
  output logic [NUM_DRV-1:0] grant,
  output logic [NUM_DRV-1:0] grant_nxt
);

  logic          lock;
  logic [IW-1:0] ptr;

  logic          lock_nxt;
  logic [IW-1:0] ptr_nxt;
  logic [IW-1:0] cur_idx;
  logic [IW-1:0] after_idx;
  logic [IW-1:0] base;
  logic [IW-1:0] pick_idx;
  logic [IW-1:0] jj;
  logic          held;
  logic          keep;
  logic          found;
  int            j;

  // Decide the next owner: keep a live burst, otherwise search from the pointer.
  always_comb begin
    cur_idx   = IW'(onehot_to_idx(16'(grant)));
    after_idx = (cur_idx == IW'(NUM_DRV - 1)) ? '0 : cur_idx + IW'(1);
    held      = lock && !flush;
    keep      = held && req[cur_idx] && !last[cur_idx];
    base      = held ? after_idx : ptr;

    found    = 1'b0;
    pick_idx = '0;
    j        = 0;
    jj       = '0;
    for (int k = 0; k < NUM_DRV; k++) begin
      j = int'(base) + k;
      if (j >= NUM_DRV) begin
        j = j - NUM_DRV;
      end
      jj = IW'(j);
      if (!found && req[jj]) begin
        found    = 1'b1;
        pick_idx = jj;
      end
    end

    grant_nxt = '0;
    lock_nxt  = 1'b0;
    ptr_nxt   = ptr;
    if (enable) begin
      if (keep) begin
        grant_nxt = grant;
        lock_nxt  = 1'b1;
      end else begin
        // A burst that just ended moves the pointer past its owner.
        if (held) begin
          ptr_nxt = after_idx;
        end
        if (found) begin
          grant_nxt[pick_idx] = 1'b1;
          lock_nxt            = 1'b1;
        end
      end
    end
  end

  // Register grant, lock and pointer.
  always_ff @(posedge clk) begin
    if (rst) begin
      grant <= '0;
      lock  <= 1'b0;
      ptr   <= '0;
    end else begin
      grant <= grant_nxt;
      lock  <= lock_nxt;
      ptr   <= ptr_nxt;
    end
  end

endmodule

// File: rtl/net_resolver_bus.sv
// Registered multi-driver bus resolver modelling wand, wor, tri and trireg
// nets. WAND/WOR reduce all enabled drivers; TRI/TRIREG pass the data of a
// single driver picked by a round-robin arbiter with burst lock. TRIREG keeps
// the last driven value for DECAY idle cycles before floating (DECAY=0 keeps
// it indefinitely). Cycles with more than one enabled driver in the tri modes
// are flagged and counted in a saturating counter.
//
// All outputs update one clock after the inputs that produce them.
module net_resolver_bus
  import net_resolve_pkg::*;
#(
  parameter int WIDTH   = 8,
  parameter int NUM_DRV = 4,
  parameter int DECAY   = 4,
  parameter int CNT_W   = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [1:0]               mode,
  input  logic [NUM_DRV-1:0]       drv_en,
  input  logic [NUM_DRV*WIDTH-1:0] drv_data,
  input  logic [NUM_DRV-1:0]       drv_last,
  input  logic                     clr_cnt,
  output logic [WIDTH-1:0]         bus_out,
  output logic                     bus_valid,
  output logic                     bus_z,
  output logic [NUM_DRV-1:0]       grant,
  output logic                     conflict,
  output logic [CNT_W-1:0]         conflict_cnt
);

  localparam int             DCW      = (DECAY < 2) ? 1 : $clog2(DECAY + 1);
  localparam logic [DCW-1:0] DECAY_LD = DCW'(DECAY);

  logic [1:0]         mode_q;
  logic               flush;
  logic               tri_mode;
  logic               any_en;
  logic               hold_ok;
  logic               conflict_nxt;
  logic [NUM_DRV-1:0] grant_nxt;
  logic [WIDTH-1:0]   and_v;
  logic [WIDTH-1:0]   or_v;
  logic [WIDTH-1:0]   mux_v;
  logic [WIDTH-1:0]   out_nxt;
  logic               valid_nxt;
  logic               z_nxt;
  logic [DCW-1:0]     dcnt;
  logic [DCW-1:0]     dcnt_nxt;
  logic [CNT_W-1:0]   cnt_nxt;

  // A mode change drops any lock and any trireg charge on the next decision.
  assign flush    = (mode != mode_q);
  assign tri_mode = mode[1];
  assign any_en   = |drv_en;

  rr_lock_arbiter #(
    .NUM_DRV (NUM_DRV)
  ) u_arb (
    .clk       (clk),
    .rst       (rst),
    .enable    (tri_mode),
    .flush     (flush),
    .req       (drv_en),
    .last      (drv_last),
    .grant     (grant),
    .grant_nxt (grant_nxt)
  );

  // Wired-AND / wired-OR reductions and the granted-driver data mux.
  always_comb begin
    and_v = '1;
    or_v  = '0;
    mux_v = '0;
    for (int i = 0; i < NUM_DRV; i++) begin
      if (drv_en[i]) begin
        and_v &= drv_data[i*WIDTH +: WIDTH];
        or_v  |= drv_data[i*WIDTH +: WIDTH];
      end
      if (grant_nxt[i]) begin
        mux_v |= drv_data[i*WIDTH +: WIDTH];
      end
    end
  end

  // Resolve the next bus value, trireg retention and the decay countdown.
  always_comb begin
    // Retention needs an existing charge (bus not already floating) in an
    // unchanged TRIREG mode, and either no decay limit or time remaining.
    hold_ok = (mode == MODE_TRIREG) && !flush && !bus_z &&
              ((DECAY == 0) || (dcnt != '0));

    out_nxt   = '0;
    valid_nxt = 1'b0;
    z_nxt     = 1'b1;
    if (any_en) begin
      valid_nxt = 1'b1;
      z_nxt     = 1'b0;
      case (mode)
        MODE_WAND: out_nxt = and_v;
        MODE_WOR:  out_nxt = or_v;
        default:   out_nxt = mux_v;
      endcase
    end else if (hold_ok) begin
      out_nxt = bus_out;
      z_nxt   = 1'b0;
    end

    if (any_en) begin
      dcnt_nxt = DECAY_LD;
    end else if (flush) begin
      dcnt_nxt = '0;
    end else if (dcnt != '0) begin
      dcnt_nxt = dcnt - DCW'(1);
    end else begin
      dcnt_nxt = '0;
    end
  end

  // Contention detection and the saturating counter; clear beats increment.
  always_comb begin
    conflict_nxt = tri_mode && (popcount16(16'(drv_en)) > 5'd1);
    cnt_nxt      = conflict_cnt;
    if (clr_cnt) begin
      cnt_nxt = '0;
    end else if (conflict_nxt && (conflict_cnt != '1)) begin
      cnt_nxt = conflict_cnt + CNT_W'(1);
    end
  end

  // Output and bookkeeping registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      bus_out      <= '0;
      bus_valid    <= 1'b0;
      bus_z        <= 1'b1;
      conflict     <= 1'b0;
      conflict_cnt <= '0;
      dcnt         <= '0;
      mode_q       <= MODE_WAND;
    end else begin
      bus_out      <= out_nxt;
      bus_valid    <= valid_nxt;
      bus_z        <= z_nxt;
      conflict     <= conflict_nxt;
      conflict_cnt <= cnt_nxt;
      dcnt         <= dcnt_nxt;
      mode_q       <= mode;
    end
  end

endmodule

// File: tb/tb_net_resolver_bus.sv
// Bench for net_resolver_bus (WIDTH=8, NUM_DRV=4, DECAY=4, CNT_W=8).
module tb_net_resolver_bus;

  localparam int WIDTH   = 8;
  localparam int NUM_DRV = 4;
  localparam int DECAY   = 4;
  localparam int CNT_W   = 8;

  logic        clk = 1'b0;
  logic        rst;
  logic [1:0]  mode;
  logic [3:0]  drv_en;
  logic [31:0] drv_data;
  logic [3:0]  drv_last;
  logic        clr_cnt;
  logic [7:0]  bus_out;
  logic        bus_valid;
  logic        bus_z;
  logic [3:0]  grant;
  logic        conflict;
  logic [7:0]  conflict_cnt;

  int errors = 0;
  int checks = 0;

  // Expected {bus_out, bus_valid, bus_z, grant, conflict, conflict_cnt}.
  logic [22:0] exp_q[$];

  // Reference model state.
  logic [7:0] m_out;
  logic       m_valid;
  logic       m_z;
  logic [3:0] m_grant;
  logic       m_conf;
  logic [7:0] m_cnt;
  int         m_ptr;
  logic       m_lock;
  int         m_dcnt;
  logic [1:0] m_mode_prev;

  net_resolver_bus #(
    .WIDTH   (WIDTH),
    .NUM_DRV (NUM_DRV),
    .DECAY   (DECAY),
    .CNT_W   (CNT_W)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .mode         (mode),
    .drv_en       (drv_en),
    .drv_data     (drv_data),
    .drv_last     (drv_last),
    .clr_cnt      (clr_cnt),
    .bus_out      (bus_out),
    .bus_valid    (bus_valid),
    .bus_z        (bus_z),
    .grant        (grant),
    .conflict     (conflict),
    .conflict_cnt (conflict_cnt)
  );

  // Clock
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Behavioural model of one clock: compute next outputs and queue them.
  task automatic model_step(input logic r, input logic [1:0] m, input logic [3:0] en,
                            input logic [31:0] data, input logic [3:0] last,
                            input logic clr);
    logic [3:0] n_grant;
    logic       n_lock;
    logic       flush;
    logic       tri_m;
    logic       held;
    logic       conf;
    logic [7:0] v;
    int         g_idx;
    int         cnt_en;
    int         j;
    if (r) begin
      m_out = 8'h00; m_valid = 1'b0; m_z = 1'b1; m_grant = 4'h0; m_conf = 1'b0;
      m_cnt = 8'h00; m_ptr = 0; m_lock = 1'b0; m_dcnt = 0; m_mode_prev = 2'd0;
    end else begin
      flush = (m != m_mode_prev);
      tri_m = m[1];
      g_idx = 0;
      for (int i = 0; i < 4; i++) if (m_grant[i]) g_idx = i;
      held    = m_lock && !flush;
      n_grant = 4'h0;
      n_lock  = 1'b0;
      if (tri_m) begin
        if (held && en[2'(g_idx)] && !last[2'(g_idx)]) begin
          n_grant = m_grant;
          n_lock  = 1'b1;
        end else begin
          if (held) m_ptr = (g_idx + 1) % 4;
          for (int k = 0; k < 4; k++) begin
            j = (m_ptr + k) % 4;
            if (n_grant == 4'h0 && en[2'(j)]) begin
              n_grant = 4'(1) << j;
              n_lock  = 1'b1;
            end
          end
        end
      end
      cnt_en = 0;
      for (int i = 0; i < 4; i++) if (en[i]) cnt_en++;
      if (en != 4'h0) begin
        if (m == 2'd0) begin
          v = 8'hFF;
          for (int i = 0; i < 4; i++) if (en[i]) v = v & data[i*8 +: 8];
        end else if (m == 2'd1) begin
          v = 8'h00;
          for (int i = 0; i < 4; i++) if (en[i]) v = v | data[i*8 +: 8];
        end else begin
          v = 8'h00;
          for (int i = 0; i < 4; i++) if (n_grant[i]) v = data[i*8 +: 8];
        end
        m_out = v; m_valid = 1'b1; m_z = 1'b0;
      end else if (m == 2'd3 && !flush && !m_z && m_dcnt > 0) begin
        m_valid = 1'b0; m_z = 1'b0;
      end else begin
        m_out = 8'h00; m_valid = 1'b0; m_z = 1'b1;
      end
      if (en != 4'h0) m_dcnt = DECAY;
      else if (flush) m_dcnt = 0;
      else if (m_dcnt > 0) m_dcnt = m_dcnt - 1;
      conf = tri_m && (cnt_en > 1);
      if (clr) m_cnt = 8'h00;
      else if (conf && m_cnt != 8'hFF) m_cnt = m_cnt + 8'd1;
      m_conf = conf; m_grant = n_grant; m_lock = n_lock; m_mode_prev = m;
    end
    exp_q.push_back({m_out, m_valid, m_z, m_grant, m_conf, m_cnt});
  endtask

  // Scoreboard: pop the oldest expectation and compare every output.
  task automatic compare_outputs();
    logic [22:0] e;
    if (exp_q.size() == 0) begin
      check("exp_q_empty", 32'(1), 32'(0));
      return;
    end
    e = exp_q.pop_front();
    check("bus_out",      32'(bus_out),      32'(e[22:15]));
    check("bus_valid",    32'(bus_valid),    32'(e[14]));
    check("bus_z",        32'(bus_z),        32'(e[13]));
    check("grant",        32'(grant),        32'(e[12:9]));
    check("conflict",     32'(conflict),     32'(e[8]));
    check("conflict_cnt", 32'(conflict_cnt), 32'(e[7:0]));
  endtask

  // Driver: apply one cycle of inputs, predict, clock, compare.
  task automatic step(input logic r, input logic [1:0] m, input logic [3:0] en,
                      input logic [31:0] data, input logic [3:0] last, input logic c);
    rst = r; mode = m; drv_en = en; drv_data = data; drv_last = last; clr_cnt = c;
    model_step(r, m, en, data, last, c);
    @(posedge clk);
    #1;
    compare_outputs();
  endtask

  initial begin
    rst = 1'b1; mode = 2'd0; drv_en = 4'h0; drv_data = 32'h0; drv_last = 4'h0; clr_cnt = 1'b0;

    // Reset state
    step(1, 2'd0, 4'h0, 32'h0, 4'h0, 0);
    step(1, 2'd0, 4'h0, 32'h0, 4'h0, 0);
    check("rst_bus_z", 32'(bus_z), 32'(1));
    check("rst_cnt", 32'(conflict_cnt), 32'(0));

    // WAND / WOR / no driver (drivers 2 and 3 carry junk but are disabled)
    step(0, 2'd0, 4'b0011, 32'hAA553CF0, 4'h0, 0);
    check("spec_wand", 32'(bus_out), 32'h30);
    step(0, 2'd1, 4'b0011, 32'hAA553CF0, 4'h0, 0);
    check("spec_wor", 32'(bus_out), 32'hFC);
    step(0, 2'd1, 4'b0000, 32'hAA553CF0, 4'h0, 0);
    check("spec_idle_z", 32'({bus_z, bus_valid, bus_out}), 32'({1'b1, 1'b0, 8'h00}));

    // TRI arbitration with burst lock from reset
    step(1, 2'd0, 4'h0, 32'h0, 4'h0, 0);
    step(0, 2'd2, 4'b1010, 32'h33AA1155, 4'h0, 0);
    check("spec_tri_grant", 32'(grant), 32'b0010);
    check("spec_tri_cnt1", 32'(conflict_cnt), 32'd1);
    step(0, 2'd2, 4'b1010, 32'h33AA1155, 4'h0, 0);
    step(0, 2'd2, 4'b1010, 32'h33AA1155, 4'h0, 0);
    step(0, 2'd2, 4'b1010, 32'h33AA1155, 4'b0010, 0);
    check("spec_tri_next", 32'(grant), 32'b1000);
    check("spec_tri_data", 32'(bus_out), 32'h33);
    check("spec_tri_cnt4", 32'(conflict_cnt), 32'd4);
    step(0, 2'd2, 4'b1010, 32'h33AA1155, 4'h0, 0);

    // TRIREG retention and decay
    step(0, 2'd3, 4'b0100, 32'h00A50000, 4'h0, 0);
    for (int i = 0; i < 4; i++) step(0, 2'd3, 4'h0, 32'h0, 4'h0, 0);
    check("spec_trireg_hold", 32'({bus_z, bus_out}), 32'({1'b0, 8'hA5}));
    step(0, 2'd3, 4'h0, 32'h0, 4'h0, 0);
    check("spec_trireg_float", 32'({bus_z, bus_out}), 32'({1'b1, 8'h00}));
    step(0, 2'd3, 4'b0100, 32'h00A50000, 4'h0, 0);
    step(0, 2'd3, 4'h0, 32'h0, 4'h0, 0);
    step(0, 2'd3, 4'h0, 32'h0, 4'h0, 0);
    step(0, 2'd3, 4'b0001, 32'h0000005A, 4'h0, 0);
    for (int i = 0; i < 4; i++) step(0, 2'd3, 4'h0, 32'h0, 4'h0, 0);
    check("spec_trireg_reload", 32'({bus_z, bus_out}), 32'({1'b0, 8'h5A}));
    step(0, 2'd3, 4'h0, 32'h0, 4'h0, 0);

    // Counter saturation and clear-wins
    step(0, 2'd2, 4'b1111, 32'h01020304, 4'h0, 1);
    for (int i = 0; i < 300; i++)
      step(0, 2'd2, 4'b1111, $urandom(), 4'($urandom_range(0, 15)), 0);
    check("spec_cnt_sat", 32'(conflict_cnt), 32'hFF);
    step(0, 2'd2, 4'b1111, 32'h01020304, 4'h0, 1);
    check("spec_cnt_clr", 32'(conflict_cnt), 32'h00);

    // Reset mid-burst
    step(0, 2'd2, 4'b0010, 32'h44332211, 4'h0, 0);
    step(0, 2'd2, 4'b0100, 32'h44332211, 4'h0, 0);
    check("spec_pre_rst_grant", 32'(grant), 32'b0100);
    step(1, 2'd2, 4'b1111, 32'h44332211, 4'h0, 0);
    check("spec_rst_grant", 32'(grant), 32'h0);
    check("spec_rst_z", 32'(bus_z), 32'(1));
    step(0, 2'd2, 4'b1111, 32'h44332211, 4'h0, 0);
    check("spec_rst_rr0", 32'(grant), 32'b0001);

    // TRI -> WOR while locked, then back to TRI from the saved pointer
    step(0, 2'd2, 4'b0011, 32'h0000F00F, 4'b0001, 0);
    check("spec_lock_g1", 32'(grant), 32'b0010);
    step(0, 2'd1, 4'b0011, 32'h0000F00F, 4'h0, 0);
    check("spec_wor_grant0", 32'(grant), 32'h0);
    check("spec_wor_or", 32'(bus_out), 32'hFF);
    step(0, 2'd2, 4'b0111, 32'h00C3F00F, 4'h0, 0);
    check("spec_back_tri", 32'(grant), 32'b0010);

    // Random traffic
    begin
      logic [1:0] rm;
      rm = 2'd2;
      for (int i = 0; i < 400; i++) begin
        if ($urandom_range(0, 7) == 0) rm = 2'($urandom_range(0, 3));
        step(($urandom_range(0, 49) == 0), rm, 4'($urandom_range(0, 15)), $urandom(),
             4'(($urandom_range(0, 2) == 0) ? $urandom_range(0, 15) : 0),
             ($urandom_range(0, 15) == 0));
      end
    end

    check("exp_q_drained", 32'(exp_q.size()), 32'(0));
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
